rf_write_queue: RTL and testbench

RF_WRITE_QUEUE -- requirements
Module: rf_write_queue

---
 rtl/rf_write_queue.sv | 87 ++++++++
 tb/tb_rf_write_queue.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_queue.sv
// Write-back queue in front of a register file: FIFO of {reg,data} drained when the write port is free, with read forwarding.
// Entries reach RegWrite one cycle after push at the earliest; in_ready drops while full, even if the head drains that cycle.
module rf_write_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 6,
  parameter int DW    = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [AW-1:0]            in_reg,
  input  logic [DW-1:0]            in_data,
  output logic                     in_ready,
  input  logic                     drain_en,
  output logic [AW-1:0]            WriteReg,
  output logic [DW-1:0]            WriteData,
  output logic                     RegWrite,
  input  logic [AW-1:0]            Read1,
  input  logic [AW-1:0]            Read2,
  input  logic [DW-1:0]            Data1,
  input  logic [DW-1:0]            Data2,
  output logic [DW-1:0]            Fwd1,
  output logic [DW-1:0]            Fwd2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] reg_mem  [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] cnt;
  logic          push;
  logic          pop;
  logic [PW-1:0] idx;

  assign in_ready  = (cnt < CW'(DEPTH));
  // Writes to register 0 are accepted but dropped, since r0 is never written.
  assign push      = in_valid && in_ready && (in_reg != '0);
  assign RegWrite  = (cnt != '0) && drain_en;
  assign pop       = RegWrite;
  assign WriteReg  = reg_mem[head];
  assign WriteData = data_mem[head];
  assign count     = cnt;

  // Walk entries oldest to newest so the newest match wins; the head being
  // drained is still pending this cycle and takes part.
  always_comb begin
    Fwd1 = Data1;
    Fwd2 = Data2;
    idx  = head;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (CW'(i) < cnt) begin
        if ((Read1 != '0) && (reg_mem[idx] == Read1)) Fwd1 = data_mem[idx];
        if ((Read2 != '0) && (reg_mem[idx] == Read2)) Fwd2 = data_mem[idx];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is not reset; pointers alone define which entries are live.
  always_ff @(posedge clock) begin
    if (push) begin
      reg_mem[tail]  <= in_reg;
      data_mem[tail] <= in_data;
    end
  end

endmodule

// File: tb/tb_rf_write_queue.sv
module tb_rf_write_queue;
  localparam int DEPTH = 4;
  localparam int AW = 6;
  localparam int DW = 32;

  logic          clock;
  logic          reset;
  logic          in_valid;
  logic [AW-1:0] in_reg;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          drain_en;
  logic [AW-1:0] WriteReg;
  logic [DW-1:0] WriteData;
  logic          RegWrite;
  logic [AW-1:0] Read1, Read2;
  logic [DW-1:0] Data1, Data2;
  logic [DW-1:0] Fwd1, Fwd2;
  logic [$clog2(DEPTH):0] count;

  typedef struct packed {
    logic [AW-1:0] r;
    logic [DW-1:0] d;
  } ent_t;

  ent_t exp_q[$];
  int   mcnt;
  int   checks;
  int   fails;

  rf_write_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_reg(in_reg),
    .in_data(in_data), .in_ready(in_ready), .drain_en(drain_en),
    .WriteReg(WriteReg), .WriteData(WriteData), .RegWrite(RegWrite),
    .Read1(Read1), .Read2(Read2), .Data1(Data1), .Data2(Data2),
    .Fwd1(Fwd1), .Fwd2(Fwd2), .count(count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: tracks occupancy and the expected drain order.
  always @(posedge clock) begin
    logic acc;
    logic pp;
    if (reset) begin
      exp_q.delete();
      mcnt = 0;
    end else begin
      pp  = drain_en && (mcnt != 0);
      acc = in_valid && (mcnt < DEPTH);
      if (acc && (in_reg != '0)) begin
        exp_q.push_back('{r: in_reg, d: in_data});
        mcnt = mcnt + 1;
      end
      if (pp) mcnt = mcnt - 1;
    end
  end

  // Monitor: every drained write must match the oldest expected entry.
  always @(negedge clock) begin
    ent_t e;
    if (!reset) begin
      chk("mon_regwrite", 64'(RegWrite), 64'(drain_en && (mcnt != 0)));
      chk("mon_count", 64'(count), 64'(mcnt));
      chk("mon_in_ready", 64'(in_ready), 64'(mcnt < DEPTH));
      if (RegWrite) begin
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL mon_unexpected_write: got reg %0d expected no write", WriteReg);
        end else begin
          e = exp_q.pop_front();
          chk("mon_write_reg", 64'(WriteReg), 64'(e.r));
          chk("mon_write_data", 64'(WriteData), 64'(e.d));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic neg();
    @(negedge clock);
  endtask

  task automatic push_held(input logic [AW-1:0] r, input logic [DW-1:0] d);
    in_valid = 1'b1; in_reg = r; in_data = d;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0; fails = 0; mcnt = 0;
    reset = 1'b1; in_valid = 1'b0; in_reg = '0; in_data = '0; drain_en = 1'b1;
    Read1 = '0; Read2 = '0; Data1 = '0; Data2 = '0;
    tick(); tick();
    reset = 1'b0;
    neg();
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_regwrite", 64'(RegWrite), 64'd0);

    // Single write: one-cycle latency then drained
    tick();
    in_valid = 1'b1; in_reg = 6'd5; in_data = 32'hAAAA0001;
    neg();
    chk("t1_no_early_write", 64'(RegWrite), 64'd0);
    tick();
    in_valid = 1'b0;
    neg();
    chk("t1_regwrite", 64'(RegWrite), 64'd1);
    chk("t1_wreg", 64'(WriteReg), 64'd5);
    chk("t1_wdata", 64'(WriteData), 64'hAAAA0001);
    tick();
    neg();
    chk("t1_idle", 64'(RegWrite), 64'd0);
    chk("t1_count", 64'(count), 64'd0);

    // Fill to full, hold a fifth request, then drain in order
    tick();
    drain_en = 1'b0;
    for (int r = 1; r <= 4; r++) push_held(AW'(r), 32'hB0 + 32'(r));
    in_reg = 6'd9; in_data = 32'h99;
    neg();
    chk("t2_full_count", 64'(count), 64'd4);
    chk("t2_full_ready", 64'(in_ready), 64'd0);
    tick();
    neg();
    chk("t2_held_count", 64'(count), 64'd4);
    tick();
    drain_en = 1'b1;
    neg();
    chk("t2_w1", 64'(WriteReg), 64'd1);
    chk("t2_full_pop_ready", 64'(in_ready), 64'd0);
    tick();
    neg();
    chk("t2_w2", 64'(WriteReg), 64'd2);
    chk("t2_count3", 64'(count), 64'd3);
    tick();
    in_valid = 1'b0;
    neg();
    chk("t2_w3", 64'(WriteReg), 64'd3);
    chk("t2_count_pushpop", 64'(count), 64'd3);
    tick(); neg();
    chk("t2_w4", 64'(WriteReg), 64'd4);
    tick(); neg();
    chk("t2_w9", 64'(WriteReg), 64'd9);
    tick(); neg();
    chk("t2_empty", 64'(count), 64'd0);

    // Forwarding: newest match wins, incoming request not forwarded
    tick();
    drain_en = 1'b0;
    push_held(6'd7, 32'h11);
    push_held(6'd7, 32'h22);
    in_valid = 1'b0;
    Read1 = 6'd7; Data1 = 32'h99; Read2 = 6'd7; Data2 = 32'h55;
    neg();
    chk("t3_fwd1_newest", 64'(Fwd1), 64'h22);
    chk("t3_fwd2_newest", 64'(Fwd2), 64'h22);
    tick();
    in_valid = 1'b1; in_reg = 6'd7; in_data = 32'h33;
    neg();
    chk("t3_no_fwd_incoming", 64'(Fwd1), 64'h22);
    tick();
    in_valid = 1'b0; Read2 = 6'd0;
    neg();
    chk("t3_fwd1_after_push", 64'(Fwd1), 64'h33);
    chk("t3_fwd2_r0", 64'(Fwd2), 64'h55);
    tick();
    Read2 = 6'd3; drain_en = 1'b1;
    neg();
    chk("t3_fwd2_miss", 64'(Fwd2), 64'h55);
    tick(); tick();
    neg();
    chk("t3_head_count", 64'(count), 64'd1);
    chk("t3_fwd_head_draining", 64'(Fwd1), 64'h33);
    tick(); neg();
    chk("t3_fwd_drained", 64'(Fwd1), 64'h99);

    // Register 0 writes are dropped
    tick();
    in_valid = 1'b1; in_reg = 6'd0; in_data = 32'hFFFF;
    neg();
    chk("t4_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    neg();
    chk("t4_count", 64'(count), 64'd0);
    chk("t4_no_write", 64'(RegWrite), 64'd0);

    // Steady push+pop at count 2, tail wrapping several times
    tick();
    drain_en = 1'b0;
    push_held(6'd10, 32'hC000_0100);
    push_held(6'd11, 32'hC000_0101);
    drain_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_reg = AW'(12 + i); in_data = 32'hC000_0000 + 32'(i);
      neg();
      chk("t5_count_steady", 64'(count), 64'd2);
      chk("t5_order", 64'(WriteReg), 64'(10 + i));
      tick();
    end
    in_valid = 1'b0;
    neg();
    chk("t5_tail20", 64'(WriteReg), 64'd20);
    tick(); neg();
    chk("t5_tail21", 64'(WriteReg), 64'd21);
    tick(); neg();
    chk("t5_empty", 64'(count), 64'd0);

    // Reset with entries pending
    tick();
    drain_en = 1'b0; Read1 = 6'd21; Data1 = 32'h1234;
    push_held(6'd20, 32'hD0);
    push_held(6'd21, 32'hD1);
    push_held(6'd22, 32'hD2);
    in_valid = 1'b0;
    neg();
    chk("t6_count3", 64'(count), 64'd3);
    chk("t6_fwd_pending", 64'(Fwd1), 64'hD1);
    tick();
    reset = 1'b1; drain_en = 1'b1; in_valid = 1'b1; in_reg = 6'd5; in_data = 32'h77;
    tick();
    reset = 1'b0; in_valid = 1'b0;
    neg();
    chk("t6_rst_count", 64'(count), 64'd0);
    chk("t6_rst_regwrite", 64'(RegWrite), 64'd0);
    chk("t6_rst_ready", 64'(in_ready), 64'd1);
    chk("t6_rst_fwd", 64'(Fwd1), 64'h1234);

    tick(); tick();
    neg();
    chk("end_scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
